// File: rtl/key_step_pkg.sv
// Shared types and constants for the push-button step conditioner.
package key_step_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } chan_state_e;

    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;
    localparam int DEF_REPEAT_EN       = 1;

endpackage

// File: rtl/key_channel.sv
// One push-button: two-flop synchroniser, counter debounce and press/auto-repeat FSM.
module key_channel
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic held,
    output logic pulse
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int T_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TM_W   = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] RD_LAST = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] RP_LAST = TM_W'(REPEAT_PERIOD - 1);

    logic [1:0]      sync_q, sync_d;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    chan_state_e     state_q, state_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic            press_s;
    logic            pulse_s;

    assign press_s = ~sync_q[1];

    // Synchroniser shift and debounce counter next-state.
    always_comb begin
        sync_d   = {sync_q[0], key_n};
        stable_d = stable_q;
        db_cnt_d = {DB_W{1'b0}};
        if (press_s == stable_q) begin
            db_cnt_d = {DB_W{1'b0}};
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = ~stable_q;
            db_cnt_d = {DB_W{1'b0}};
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Channel FSM: release always wins over a timer expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_s = 1'b0;
        case (state_q)
            RELEASED: begin
                timer_d = {TM_W{1'b0}};
                if (stable_q) begin
                    state_d = HELD_DELAY;
                    pulse_s = 1'b1;
                end else begin
                    state_d = RELEASED;
                end
            end
            HELD_DELAY: begin
                if (!stable_q) begin
                    state_d = RELEASED;
                    timer_d = {TM_W{1'b0}};
                end else if (timer_q == RD_LAST) begin
                    if (REPEAT_EN != 0) begin
                        state_d = HELD_REPEAT;
                        timer_d = {TM_W{1'b0}};
                        pulse_s = 1'b1;
                    end else begin
                        timer_d = timer_q;
                    end
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            HELD_REPEAT: begin
                if (!stable_q) begin
                    state_d = RELEASED;
                    timer_d = {TM_W{1'b0}};
                end else if (timer_q == RP_LAST) begin
                    timer_d = {TM_W{1'b0}};
                    pulse_s = 1'b1;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                timer_d = {TM_W{1'b0}};
            end
        endcase
    end

    // State registers; synchroniser resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b0;
            db_cnt_q <= {DB_W{1'b0}};
            state_q  <= RELEASED;
            timer_q  <= {TM_W{1'b0}};
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
        end
    end

    assign held  = stable_q;
    assign pulse = pulse_s;

endmodule

// File: rtl/key_step_conditioner.sv
// Two debounced key channels, same-cycle conflict suppression and registered step pulses.
module key_step_conditioner
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] KEY,
    output logic       step_right,
    output logic       step_left,
    output logic [1:0] held
);

    logic [1:0] pulse_s;
    logic       step_right_q, step_right_d;
    logic       step_left_q, step_left_d;

    key_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (REPEAT_EN)
    ) u_right (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (KEY[KEY_RIGHT]),
        .held  (held[KEY_RIGHT]),
        .pulse (pulse_s[KEY_RIGHT])
    );

    key_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (REPEAT_EN)
    ) u_left (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (KEY[KEY_LEFT]),
        .held  (held[KEY_LEFT]),
        .pulse (pulse_s[KEY_LEFT])
    );

    // Opposite moves in the same cycle cancel each other.
    always_comb begin
        step_right_d = pulse_s[KEY_RIGHT] & ~pulse_s[KEY_LEFT];
        step_left_d  = pulse_s[KEY_LEFT] & ~pulse_s[KEY_RIGHT];
    end

    // Output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            step_right_q <= 1'b0;
            step_left_q  <= 1'b0;
        end else begin
            step_right_q <= step_right_d;
            step_left_q  <= step_left_d;
        end
    end

    assign step_right = step_right_q;
    assign step_left  = step_left_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Scoreboard bench: a rule-level model predicts step pulses for a repeating and a non-repeating instance.
module tb_key_step_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key;
    logic       sr_a, sl_a, sr_b, sl_b;
    logic [1:0] held_a, held_b;

    always #5 clk = ~clk;

    key_step_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1)) dut_a (
        .CLOCK_50(clk), .reset(reset), .KEY(key),
        .step_right(sr_a), .step_left(sl_a), .held(held_a));

    key_step_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(0)) dut_b (
        .CLOCK_50(clk), .reset(reset), .KEY(key),
        .step_right(sr_b), .step_left(sl_b), .held(held_b));

    typedef struct {
        int t;
        bit r;
        bit l;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    int  total = 0;
    int  bad   = 0;
    int  edge_n = 0;

    // Model state: accepted level, edge at which the press was accepted,
    // two-edge synchroniser delay, and the recent synced samples.
    bit  m_held  [2];
    int  m_press [2];
    bit  m_dl    [2][2];
    bit  win     [2][DB];
    int  nsamp   [2];

    task automatic model_step();
        bit p [2][2];
        bit s;
        bit all_diff;
        int off;
        ev_t e;
        edge_n++;
        for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) p[d][c] = 1'b0;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_held[c] = 1'b0; nsamp[c] = 0; m_dl[c][0] = 1'b0; m_dl[c][1] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                // pulses: at press+1, then press+1+RD, +RP, ... while still held
                if (m_held[c]) begin
                    off = edge_n - 1 - m_press[c];
                    p[0][c] = (off == 0) || (off >= RD && ((off - RD) % RP) == 0);
                    p[1][c] = (off == 0);
                end
                s = m_dl[c][1];
                m_dl[c][1] = m_dl[c][0];
                m_dl[c][0] = ~key[c];
                for (int i = DB - 1; i > 0; i--) win[c][i] = win[c][i-1];
                win[c][0] = s;
                if (nsamp[c] < DB) nsamp[c]++;
                all_diff = (nsamp[c] == DB);
                for (int i = 0; i < DB; i++) if (win[c][i] == m_held[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_held[c] = ~m_held[c];
                    if (m_held[c]) m_press[c] = edge_n;
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (p[d][0] ^ p[d][1]) begin
                    e.t = edge_n; e.r = p[d][0]; e.l = p[d][1];
                    if (d == 0) qa.push_back(e); else qb.push_back(e);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic pop_q(input int d);
        if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
    endtask

    task automatic check_dut(input int d, input logic r, input logic l, input logic [1:0] h);
        ev_t e;
        bit  have;
        total++;
        if (h !== {m_held[1], m_held[0]}) begin
            bad++;
            $display("FAIL held dut%0d t=%0d got=%b exp=%b", d, edge_n, h, {m_held[1], m_held[0]});
        end
        forever begin
            have = (d == 0) ? (qa.size() > 0) : (qb.size() > 0);
            if (!have) break;
            if (d == 0) e = qa[0]; else e = qb[0];
            if (e.t >= edge_n) break;
            total++; bad++;
            $display("FAIL missing_step dut%0d t=%0d got=none exp r=%0b l=%0b at t=%0d", d, edge_n, e.r, e.l, e.t);
            pop_q(d);
        end
        if (r === 1'b1 || l === 1'b1) begin
            total++;
            have = (d == 0) ? (qa.size() > 0) : (qb.size() > 0);
            if (have) begin
                if (d == 0) e = qa[0]; else e = qb[0];
            end
            if (!have || e.t != edge_n || e.r != r || e.l != l) begin
                bad++;
                $display("FAIL unexpected_step dut%0d t=%0d got r=%b l=%b exp none", d, edge_n, r, l);
            end
            if (have && e.t == edge_n) pop_q(d);
        end
    endtask

    initial forever begin
        @(negedge clk);
        check_dut(0, sr_a, sl_a, held_a);
        check_dut(1, sr_b, sl_b, held_b);
    end

    task automatic measure(input string name, input int k, input bit left, input int budget);
        int seen;
        seen = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (seen < 0 && ((left && sl_a) || (!left && sr_a))) seen = edge_n;
        end
        total++;
        if (seen != k + DB + 2) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=%0d", name, seen, k + DB + 2);
        end
    endtask

    initial begin
        int k;
        reset = 1'b1;
        key   = 2'b11;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        key[0] = 1'b0; k = edge_n + 1;
        measure("clean_press", k, 1'b0, 12);
        key[0] = 1'b1;
        repeat (14) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            key[1] = ~key[1];
            repeat (2) @(negedge clk);
        end
        key[1] = 1'b0; k = edge_n + 1;
        measure("bounce_press", k, 1'b1, 80);
        key[1] = 1'b1;
        repeat (20) @(negedge clk);

        key = 2'b00;
        repeat (40) @(negedge clk);
        key = 2'b11;
        repeat (20) @(negedge clk);

        key[0] = 1'b0;
        repeat (35) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; k = edge_n + 1;
        measure("reset_repress", k, 1'b0, 40);
        key[0] = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 250 == 0) begin
                key = 2'($urandom_range(0, 3));
                repeat ($urandom_range(30, 70)) @(negedge clk);
            end
            if ($urandom_range(0, 9) == 0) key[0] = ~key[0];
            if ($urandom_range(0, 9) == 0) key[1] = ~key[1];
            reset = ($urandom_range(0, 599) == 0);
        end

        reset = 1'b0;
        key   = 2'b11;
        repeat (100) @(negedge clk);
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d/%0d exp=0/0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
